bcd_updown_counter: RTL and testbench

Parametrised multi-digit BCD up/down counter with an integrated prescaler. It advances one count per DIV clock cycles and is the general successor of the fixed single-digit divide-and-count block. It adds digit cascading, direction control, pause, a wrap/saturate mode and optional parallel load. It sits between the 50 MHz system clock domain and display/timing logic, for example 7-segment stopwatch and timer digits.

---
 rtl/counter_pkg.sv | 14 +
 rtl/bcd_updown_counter_tick_gen.sv | 32 +++
 rtl/bcd_updown_counter.sv | 111 +++++++++++
 tb/tb_bcd_updown_counter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types and helpers for the BCD counter family.
// Used by bcd_updown_counter and its tick_gen prescaler.
package counter_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  // Bits needed to hold 0..div-1, never less than one.
  function automatic int presc_width(input int div);
    return (div <= 1) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/bcd_updown_counter_tick_gen.sv
// Prescaler for bcd_updown_counter: a single-cycle TICK every DIV enabled cycles.
// The phase is frozen while ENABLE is low and is cleared by CLEAR or reset.
module tick_gen
  import counter_pkg::*;
#(
  parameter int DIV = 12500000
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic ENABLE,
  input  logic CLEAR,
  output logic TICK
);

  localparam int PW = presc_width(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] presc;

  assign TICK = ENABLE && (presc == LAST);

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      presc <= '0;
    end else if (CLEAR) begin
      presc <= '0;
    end else if (ENABLE) begin
      presc <= TICK ? '0 : presc + 1'b1;
    end
  end

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter stepped by an integrated prescaler.
// Optional parallel load is built only when COUNTER_LOAD_EN is defined.
module bcd_updown_counter
  import counter_pkg::*;
#(
  parameter int DIV    = 12500000,
  parameter int DIGITS = 2,
  parameter int WRAP   = 1
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic                  ENABLE,
  input  logic                  UP_DOWN,
`ifdef COUNTER_LOAD_EN
  input  logic                  LOAD,
  input  logic [4*DIGITS-1:0]   LOAD_VALUE,
`endif
  output logic [4*DIGITS-1:0]   COUNT,
  output logic                  TICK,
  output logic                  TC
);

  localparam bit SATURATE = (WRAP == 0);

  logic [4*DIGITS-1:0] count_q;
  logic [4*DIGITS-1:0] count_nxt;
  logic [DIGITS:0]     nine_chain;
  logic [DIGITS:0]     zero_chain;
  logic [DIGITS-1:0]   nxt_nine;
  logic [DIGITS-1:0]   nxt_zero;
  logic                clear;
  logic                at_limit;
  logic                reach_limit;
  logic                hold;
  logic                tc_event;
  logic                tc_q;

`ifdef COUNTER_LOAD_EN
  logic [4*DIGITS-1:0] load_clamped;
  assign clear = LOAD;
`else
  assign clear = 1'b0;
`endif

  tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .CLK    (CLK),
    .RSTn   (RSTn),
    .ENABLE (ENABLE),
    .CLEAR  (clear),
    .TICK   (TICK)
  );

  // chain[k] is high when every digit below k sits at the carry/borrow value
  assign nine_chain[0] = 1'b1;
  assign zero_chain[0] = 1'b1;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_digit_t cur;
    bcd_digit_t inc;
    bcd_digit_t dec;
    logic       step;

    assign cur  = count_q[4*k +: 4];
    assign inc  = (cur == BCD_MAX) ? 4'd0 : cur + 4'd1;
    assign dec  = (cur == 4'd0) ? BCD_MAX : cur - 4'd1;
    assign step = UP_DOWN ? nine_chain[k] : zero_chain[k];

    assign nine_chain[k+1] = nine_chain[k] && (cur == BCD_MAX);
    assign zero_chain[k+1] = zero_chain[k] && (cur == 4'd0);

    assign count_nxt[4*k +: 4] = !step ? cur : (UP_DOWN ? inc : dec);
    assign nxt_nine[k] = (count_nxt[4*k +: 4] == BCD_MAX);
    assign nxt_zero[k] = (count_nxt[4*k +: 4] == 4'd0);

`ifdef COUNTER_LOAD_EN
    assign load_clamped[4*k +: 4] = (LOAD_VALUE[4*k +: 4] > BCD_MAX) ? BCD_MAX
                                                                     : LOAD_VALUE[4*k +: 4];
`endif
  end

  assign at_limit    = UP_DOWN ? nine_chain[DIGITS] : zero_chain[DIGITS];
  assign reach_limit = UP_DOWN ? (&nxt_nine) : (&nxt_zero);
  assign hold        = SATURATE && at_limit;
  // Wrap mode flags the rollover itself; saturate mode flags arrival at the limit only.
  assign tc_event    = SATURATE ? (!at_limit && reach_limit) : at_limit;

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      count_q <= '0;
      tc_q    <= 1'b0;
`ifdef COUNTER_LOAD_EN
    end else if (LOAD) begin
      count_q <= load_clamped;
      tc_q    <= 1'b0;
`endif
    end else if (TICK) begin
      if (!hold) begin
        count_q <= count_nxt;
      end
      tc_q <= tc_event;
    end else begin
      tc_q <= 1'b0;
    end
  end

  assign COUNT = count_q;
  assign TC    = tc_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Scoreboard bench for bcd_updown_counter: a wrap and a saturate instance share stimulus.
// Expected outputs come from an integer-valued reference model and are checked by a monitor.
module tb_bcd_updown_counter;

  localparam int DIV    = 4;
  localparam int DIGITS = 2;
  localparam int MAXV   = 99;

  typedef struct packed {
    logic [7:0] count;
    logic       tick;
    logic       tc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       up_down = 1'b1;
  logic       load = 1'b0;
  logic [7:0] load_value = 8'h00;

  logic [7:0] count_w, count_s;
  logic       tick_w, tick_s, tc_w, tc_s;

  exp_t q_w[$];
  exp_t q_s[$];

  int checks = 0;
  int errors = 0;

  // reference model: plain integer count and prescaler phase
  int m_p = 0;
  int m_c[2] = '{0, 0};
  bit m_tc[2] = '{1'b0, 1'b0};

  always #5 clk = ~clk;

  bcd_updown_counter #(.DIV(DIV), .DIGITS(DIGITS), .WRAP(1)) dut_wrap (
    .CLK        (clk),
    .RSTn       (rst_n),
    .ENABLE     (enable),
    .UP_DOWN    (up_down),
`ifdef COUNTER_LOAD_EN
    .LOAD       (load),
    .LOAD_VALUE (load_value),
`endif
    .COUNT      (count_w),
    .TICK       (tick_w),
    .TC         (tc_w)
  );

  bcd_updown_counter #(.DIV(DIV), .DIGITS(DIGITS), .WRAP(0)) dut_sat (
    .CLK        (clk),
    .RSTn       (rst_n),
    .ENABLE     (enable),
    .UP_DOWN    (up_down),
`ifdef COUNTER_LOAD_EN
    .LOAD       (load),
    .LOAD_VALUE (load_value),
`endif
    .COUNT      (count_s),
    .TICK       (tick_s),
    .TC         (tc_s)
  );

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] hi, lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  function automatic int clamp_val(input logic [7:0] lv);
    int hi, lo;
    hi = int'(lv[7:4]);
    lo = int'(lv[3:0]);
    if (hi > 9) hi = 9;
    if (lo > 9) lo = 9;
    return hi * 10 + lo;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // one clock of stimulus: push expected outputs for this cycle, then advance the model
  task automatic step(input bit r, input bit e, input bit u, input bit l, input logic [7:0] lv);
    bit tick, ld;
    @(posedge clk);
    #1;
    rst_n      = r;
    enable     = e;
    up_down    = u;
    load       = l;
    load_value = lv;
`ifdef COUNTER_LOAD_EN
    ld = l;
`else
    ld = 1'b0;
`endif
    tick = e && (m_p == DIV - 1);
    q_w.push_back('{to_bcd(m_c[0]), tick, m_tc[0]});
    q_s.push_back('{to_bcd(m_c[1]), tick, m_tc[1]});
    if (!r) begin
      m_p = 0;
      foreach (m_c[i]) begin m_c[i] = 0; m_tc[i] = 1'b0; end
    end else if (ld) begin
      m_p = 0;
      foreach (m_c[i]) begin m_c[i] = clamp_val(lv); m_tc[i] = 1'b0; end
    end else begin
      if (e) m_p = tick ? 0 : m_p + 1;
      foreach (m_c[i]) begin
        bit wrap;
        wrap = (i == 0);
        m_tc[i] = 1'b0;
        if (tick) begin
          if (u) begin
            if (m_c[i] == MAXV) begin
              if (wrap) begin m_c[i] = 0; m_tc[i] = 1'b1; end
            end else begin
              m_c[i]++;
              m_tc[i] = !wrap && (m_c[i] == MAXV);
            end
          end else begin
            if (m_c[i] == 0) begin
              if (wrap) begin m_c[i] = MAXV; m_tc[i] = 1'b1; end
            end else begin
              m_c[i]--;
              m_tc[i] = !wrap && (m_c[i] == 0);
            end
          end
        end
      end
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q_w.size() > 0) begin
      e = q_w.pop_front();
      check("wrap_count", int'(count_w), int'(e.count));
      check("wrap_tick",  int'(tick_w),  int'(e.tick));
      check("wrap_tc",    int'(tc_w),    int'(e.tc));
    end
    if (q_s.size() > 0) begin
      e = q_s.pop_front();
      check("sat_count", int'(count_s), int'(e.count));
      check("sat_tick",  int'(tick_s),  int'(e.tick));
      check("sat_tc",    int'(tc_s),    int'(e.tc));
    end
  end

  initial begin
    bit dir;
    // reset with ENABLE high, then count up past the 99 -> 00 wrap
    repeat (2) step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    repeat (410) step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    // down from zero: wrap to 99, later the 10 -> 09 borrow
    repeat (2) step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    repeat (380) step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    // pause with prescaler at 2
    repeat (2) step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    repeat (6) step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    repeat (10) step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
    repeat (8) step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
`ifdef COUNTER_LOAD_EN
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'h47);
    repeat (6) step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b1, 1'b1, 8'hA3);
    repeat (3) step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'h98);
    repeat (30) step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'h55);
    repeat (3) step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00);
`endif
    // randomized: sticky direction, mostly enabled, rare reset and load
    dir = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      bit r, e, l;
      if ($urandom_range(0, 49) == 0) dir = ~dir;
      r = ($urandom_range(0, 299) != 0);
      e = ($urandom_range(0, 3) != 0);
      l = ($urandom_range(0, 59) == 0);
      step(r, e, dir, l, 8'($urandom));
    end
    @(negedge clk);
    @(negedge clk);
    check("queue_drained", q_w.size() + q_s.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
